// File: rtl/sign_condition_stage.sv
// ---------------------------------------------------------------------------
// sign_condition_stage
//
// Registered operand-conditioning stage in front of the multdiv core. It
// turns two two's-complement operands into magnitudes. It also records the
// sign corrections the core must apply afterwards:
//   - negate the product/quotient
//   - negate the remainder
// Conditioned pairs sit in a 2-entry skid buffer with valid/ready handshaking.
//
// Parameters:
//   WIDTH       operand/magnitude width in bits (>= 2)
//   SKID_DEPTH  output buffer entries; only 2 is supported
//
// Optional feature (compile-time macro SIGN_CONDITION_DIV0_EN):
//   When defined, the stage adds an out_div_zero output. It flags
//   divide-by-zero and suppresses both negate flags for that entry.
//   When undefined, the port is absent.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   in_valid        input operand pair valid
//   in_ready        stage can accept (registered)
//   in_a, in_b      operands A (dividend/multiplicand), B (divisor/multiplier)
//   in_signed       1 = operands are signed, 0 = pass through unchanged
//   in_is_div       1 = divide, 0 = multiply
//   out_valid       head entry valid
//   out_ready       consumer accepts head entry
//   out_mag_a/b     operand magnitudes
//   out_neg_result  core product/quotient must be negated
//   out_neg_rem     core remainder must be negated (divide only)
//   out_min_a/b     operand was the most-negative value in signed mode
//   out_is_div      in_is_div carried through
//   out_div_zero    (SIGN_CONDITION_DIV0_EN only) divide by zero
// ---------------------------------------------------------------------------
module sign_condition_stage #(
    parameter int WIDTH      = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    input  logic             in_is_div,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mag_a,
    output logic [WIDTH-1:0] out_mag_b,
    output logic             out_neg_result,
    output logic             out_neg_rem,
    output logic             out_min_a,
    output logic             out_min_b,
`ifdef SIGN_CONDITION_DIV0_EN
    output logic             out_div_zero,
`endif
    output logic             out_is_div
);

    // The occupancy bookkeeping below assumes exactly two entries.
    if (SKID_DEPTH != 2) begin : g_bad_skid_depth
        $error("sign_condition_stage: SKID_DEPTH must be 2");
    end

    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
        logic             neg_result;
        logic             neg_rem;
        logic             min_a;
        logic             min_b;
        logic             is_div;
`ifdef SIGN_CONDITION_DIV0_EN
        logic             div_zero;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } occ_state_e;

    occ_state_e state_q;
    occ_state_e state_d;
    entry_t     entries_q [2];
    logic       head_q;
    logic       tail;
    logic       push;
    logic       pop;
    entry_t     cond;

    logic       sa;
    logic       sb;
    logic       az;
    logic       bz;
    logic       neg_result_raw;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // With two slots, the free slot is the one opposite the head when one
    // entry is held, and the head slot itself when the buffer is empty.
    assign tail = (state_q == ONE) ? ~head_q : head_q;

    // Operand conditioning: sign extraction, negation to magnitude, and the
    // sign-correction flags the core applies once it has finished.
    // A zero operand never produces a negative result. The divide case only
    // looks at the dividend, so a zero divisor keeps the sign rule of A^B.
    always_comb begin
        cond           = '0;
        sa             = in_signed & in_a[WIDTH-1];
        sb             = in_signed & in_b[WIDTH-1];
        az             = (in_a == '0);
        bz             = (in_b == '0);
        neg_result_raw = 1'b0;

        cond.mag_a  = sa ? (~in_a + ONE_VAL) : in_a;
        cond.mag_b  = sb ? (~in_b + ONE_VAL) : in_b;
        cond.min_a  = sa & (in_a[WIDTH-2:0] == '0);
        cond.min_b  = sb & (in_b[WIDTH-2:0] == '0);
        cond.is_div = in_is_div;

        if (in_is_div) begin
            neg_result_raw = (sa ^ sb) & ~az;
        end else begin
            neg_result_raw = (sa ^ sb) & ~az & ~bz;
        end

`ifdef SIGN_CONDITION_DIV0_EN
        cond.div_zero   = in_is_div & bz;
        cond.neg_result = neg_result_raw & ~cond.div_zero;
        cond.neg_rem    = in_is_div & sa & ~cond.div_zero;
`else
        cond.neg_result = neg_result_raw;
        cond.neg_rem    = in_is_div & sa;
`endif
    end

    // Occupancy next-state.
    // A simultaneous push and pop at ONE leaves the count unchanged.
    // No push can happen at FULL because in_ready is low there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                end else if (!push && pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State, ready and buffer storage.
    // in_ready is registered from the next occupancy so out_ready never
    // reaches it combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= EMPTY;
            in_ready     <= 1'b1;
            head_q       <= 1'b0;
            entries_q[0] <= '0;
            entries_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != FULL);
            if (push) begin
                entries_q[tail] <= cond;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    assign out_valid      = (state_q != EMPTY);
    assign out_mag_a      = entries_q[head_q].mag_a;
    assign out_mag_b      = entries_q[head_q].mag_b;
    assign out_neg_result = entries_q[head_q].neg_result;
    assign out_neg_rem    = entries_q[head_q].neg_rem;
    assign out_min_a      = entries_q[head_q].min_a;
    assign out_min_b      = entries_q[head_q].min_b;
    assign out_is_div     = entries_q[head_q].is_div;
`ifdef SIGN_CONDITION_DIV0_EN
    assign out_div_zero   = entries_q[head_q].div_zero;
`endif

endmodule

// File: tb/tb_sign_condition_stage.sv
// ---------------------------------------------------------------------------
// tb_sign_condition_stage
//
// Directed bench for sign_condition_stage at WIDTH=32. Inputs change and
// outputs are sampled on the falling clock edge. Expected values are written
// out by hand for each vector.
// ---------------------------------------------------------------------------
module tb_sign_condition_stage;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             in_is_div;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mag_a;
    logic [WIDTH-1:0] out_mag_b;
    logic             out_neg_result;
    logic             out_neg_rem;
    logic             out_min_a;
    logic             out_min_b;
    logic             out_is_div;
`ifdef SIGN_CONDITION_DIV0_EN
    logic             out_div_zero;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] stream_a [8];
    logic [WIDTH-1:0] stream_b [8];

    sign_condition_stage #(
        .WIDTH(WIDTH),
        .SKID_DEPTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_signed(in_signed),
        .in_is_div(in_is_div),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mag_a(out_mag_a),
        .out_mag_b(out_mag_b),
        .out_neg_result(out_neg_result),
        .out_neg_rem(out_neg_rem),
        .out_min_a(out_min_a),
        .out_min_b(out_min_b),
`ifdef SIGN_CONDITION_DIV0_EN
        .out_div_zero(out_div_zero),
`endif
        .out_is_div(out_is_div)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic s,
                                 input logic d);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_is_div = d;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] ma,
                               input logic [WIDTH-1:0] mb, input logic nr,
                               input logic nrem, input logic mina,
                               input logic minb, input logic isdiv,
                               input logic dz);
        checkBit({tag, ".valid"}, out_valid, 1'b1);
        checkWord({tag, ".mag_a"}, out_mag_a, ma);
        checkWord({tag, ".mag_b"}, out_mag_b, mb);
        checkBit({tag, ".neg_result"}, out_neg_result, nr);
        checkBit({tag, ".neg_rem"}, out_neg_rem, nrem);
        checkBit({tag, ".min_a"}, out_min_a, mina);
        checkBit({tag, ".min_b"}, out_min_b, minb);
        checkBit({tag, ".is_div"}, out_is_div, isdiv);
`ifdef SIGN_CONDITION_DIV0_EN
        checkBit({tag, ".div_zero"}, out_div_zero, dz);
`else
        if (dz) begin
            $display("[TB] %s exercises divide-by-zero without the feature", tag);
        end
`endif
    endtask

    // One isolated transfer with out_ready high: visible one cycle after
    // acceptance, consumed on the following edge.
    task automatic runSingle(input string tag, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic s,
                             input logic d, input logic [WIDTH-1:0] ma,
                             input logic [WIDTH-1:0] mb, input logic nr,
                             input logic nrem, input logic mina,
                             input logic minb, input logic dz);
        applyStimulus(1'b1, a, b, s, d);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput(tag, ma, mb, nr, nrem, mina, minb, d, dz);
        tick();
        checkBit({tag, ".drained"}, out_valid, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        checkBit("reset.valid", out_valid, 1'b0);
        checkBit("reset.ready", in_ready, 1'b1);
        checkWord("reset.mag_a", out_mag_a, 32'h0);

        // Leave an entry pending, then reset while a transfer is offered.
        reset = 1'b0;
        applyStimulus(1'b1, 32'h1234, 32'h5678, 1'b0, 1'b0);
        tick();
        checkBit("pending.valid", out_valid, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h9999, 32'h7777, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkBit("rst_flush.valid", out_valid, 1'b0);
        checkBit("rst_flush.ready", in_ready, 1'b1);
        checkWord("rst_flush.mag_a", out_mag_a, 32'h0);
        checkWord("rst_flush.mag_b", out_mag_b, 32'h0);
        tick();
        checkBit("rst_flush.stale", out_valid, 1'b0);

        out_ready = 1'b1;
        //        tag          a             b             s     d     mag_a         mag_b         nr    nrem  mina  minb  dz
        runSingle("smul_m7_3", 32'hFFFFFFF9, 32'h00000003, 1'b1, 1'b0, 32'h00000007, 32'h00000003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runSingle("sdiv_min",  32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        runSingle("smul_a0",   32'h00000000, 32'hFFFFFFFB, 1'b1, 1'b0, 32'h00000000, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runSingle("udiv",      32'hFFFFFFF0, 32'h00000003, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runSingle("smul_minb", 32'h00000005, 32'h80000000, 1'b1, 1'b0, 32'h00000005, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        runSingle("sdiv_m7_2", 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1, 32'h00000007, 32'h00000002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runSingle("sdiv_a0",   32'h00000000, 32'hFFFFFFFD, 1'b1, 1'b1, 32'h00000000, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runSingle("smul_b0",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runSingle("smul_nn",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runSingle("umul_big",  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SIGN_CONDITION_DIV0_EN
        runSingle("sdiv_b0",   32'hFFFFFFF9, 32'h00000000, 1'b1, 1'b1, 32'h00000007, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        runSingle("sdiv_b0",   32'hFFFFFFF9, 32'h00000000, 1'b1, 1'b1, 32'h00000007, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Back-pressure: three pairs offered while the consumer stalls.
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h11, 32'h12, 1'b0, 1'b0);
        tick();
        checkBit("stall.p1_ready", in_ready, 1'b1);
        checkOutput("stall.p1", 32'h11, 32'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h21, 32'h22, 1'b0, 1'b0);
        tick();
        checkBit("stall.full_ready", in_ready, 1'b0);
        checkOutput("stall.hold1", 32'h11, 32'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h31, 32'h32, 1'b0, 1'b1);
        tick();
        checkBit("stall.p3_blocked", in_ready, 1'b0);
        checkOutput("stall.hold2", 32'h11, 32'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stall.hold3", 32'h11, 32'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        checkBit("stall.ready_rise", in_ready, 1'b1);
        checkOutput("stall.p2", 32'h21, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkBit("stall.p3_ready", in_ready, 1'b1);
        checkOutput("stall.p3", 32'h31, 32'h32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        checkBit("stall.drained", out_valid, 1'b0);

        // Streaming: one transfer per cycle, unsigned pairs pass straight through.
        for (int i = 0; i < 8; i++) begin
            stream_a[i] = $urandom;
            stream_b[i] = $urandom;
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, stream_a[i], stream_b[i], 1'b0, 1'b0);
            tick();
            checkBit($sformatf("stream%0d.ready", i), in_ready, 1'b1);
            checkOutput($sformatf("stream%0d", i), stream_a[i], stream_b[i],
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        checkBit("stream.drained", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
